// File: rtl/a2bus_stream_pkg.sv
// Shared packet layout, marker constants and filter direction encoding for the
// Apple II bus capture stream.
package a2bus_stream_pkg;

  localparam int FLAG_RW_N_BIT = 7;
  localparam int FLAG_IDX_LSB  = 4;
  localparam int FLAG_DROP_BIT = 1;
  localparam int FLAG_RST_BIT  = 0;

  localparam logic [31:0] RESET_MARKER     = 32'h0000_0001;
  localparam logic [15:0] DROP_MARKER_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    DIR_ANY   = 2'b00,
    DIR_READ  = 2'b01,
    DIR_WRITE = 2'b10,
    DIR_NEVER = 2'b11
  } flt_dir_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic [2:0]  flt_idx;
    logic [1:0]  rsvd;
    logic        drop_mk;
    logic        rst_mk;
  } packet_t;

  function automatic logic dir_ok(input flt_dir_e dir, input logic rw_n);
    case (dir)
      DIR_ANY:   dir_ok = 1'b1;
      DIR_READ:  dir_ok = rw_n;
      DIR_WRITE: dir_ok = ~rw_n;
      default:   dir_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry, forced to zero when empty.
// A push while full is ignored; the writer is expected to check full itself.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/a2bus_capture_mux.sv
// Apple II bus capture: address/direction filtering, one-cycle capture stage,
// write arbitration between reset marker, captures and drop markers, and a FIFO.
module a2bus_capture_mux
  import a2bus_stream_pkg::*;
#(
  parameter bit ENABLE      = 1'b1,
  parameter int NUM_FILTERS = 4,
  parameter int DEPTH       = 16
) (
  input  logic                        clk_logic,
  input  logic                        system_reset_n,
  input  logic                        capture_enable,
  input  logic                        flush,
  input  logic                        clear_stats,
  input  logic [15:0]                 bus_addr,
  input  logic [7:0]                  bus_data,
  input  logic                        bus_rw_n,
  input  logic                        bus_m2sel_n,
  input  logic                        bus_strobe,
  input  logic [NUM_FILTERS-1:0]      flt_en,
  input  logic [NUM_FILTERS*16-1:0]   flt_base,
  input  logic [NUM_FILTERS*16-1:0]   flt_mask,
  input  logic [NUM_FILTERS*2-1:0]    flt_dir,
  output logic                        out_valid,
  output logic [31:0]                 out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [15:0]                 drop_count,
  output logic                        overflow_flag
);

  logic       hit;
  logic [2:0] hit_idx;
  logic       cap_event;
  packet_t    cap_pkt;
  packet_t    s1_pkt;
  logic       s1_valid;
  logic       rst_mark_due;
  logic [7:0] pending_drops;
  packet_t    drop_pkt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic [31:0] push_data;
  logic       drop;
  logic       marker_push;

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (flt_en[i] &&
          (((bus_addr ^ flt_base[16*i +: 16]) & flt_mask[16*i +: 16]) == 16'h0) &&
          dir_ok(flt_dir_e'(flt_dir[2*i +: 2]), bus_rw_n)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign cap_event = ENABLE && capture_enable && bus_strobe && !bus_m2sel_n && hit;

  always_comb begin
    cap_pkt         = '0;
    cap_pkt.addr    = bus_addr;
    cap_pkt.data    = bus_data;
    cap_pkt.rw_n    = bus_rw_n;
    cap_pkt.flt_idx = hit_idx;
  end

  always_comb begin
    drop_pkt         = '0;
    drop_pkt.addr    = DROP_MARKER_ADDR;
    drop_pkt.data    = pending_drops;
    drop_pkt.drop_mk = 1'b1;
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      s1_valid     <= 1'b0;
      s1_pkt       <= '0;
      rst_mark_due <= 1'b1;
    end else begin
      s1_valid     <= cap_event;
      rst_mark_due <= 1'b0;
      if (cap_event) s1_pkt <= cap_pkt;
    end
  end

  // A capture is refused while a drop marker is owed so the marker always
  // lands ahead of any data captured after the loss.
  always_comb begin
    push        = 1'b0;
    push_data   = '0;
    drop        = 1'b0;
    marker_push = 1'b0;
    if (rst_mark_due) begin
      push      = 1'b1;
      push_data = RESET_MARKER;
      drop      = s1_valid;
    end else if (s1_valid) begin
      if (fifo_full || pending_drops != 8'd0) begin
        drop = 1'b1;
      end else begin
        push      = 1'b1;
        push_data = s1_pkt;
      end
    end else if (pending_drops != 8'd0 && !fifo_full) begin
      push        = 1'b1;
      push_data   = drop_pkt;
      marker_push = 1'b1;
    end
    if (flush) begin
      push        = 1'b0;
      drop        = 1'b0;
      marker_push = 1'b0;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      pending_drops <= '0;
    end else if (flush) begin
      pending_drops <= '0;
    end else if (drop) begin
      if (pending_drops != 8'hFF) pending_drops <= pending_drops + 8'd1;
    end else if (marker_push) begin
      pending_drops <= '0;
    end
  end

  // A drop in the same cycle as clear_stats is kept, so the count restarts at 1.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      drop_count    <= '0;
      overflow_flag <= 1'b0;
    end else if (drop) begin
      overflow_flag <= 1'b1;
      if (clear_stats)                drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_stats) begin
      drop_count    <= '0;
      overflow_flag <= 1'b0;
    end
  end

  // Stream handshake: out_data is the FIFO head and is held while out_valid is
  // high; a transfer happens on a clock edge where out_valid & out_ready.
  assign out_valid = ~fifo_empty;

  stream_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_logic),
    .rst_n (system_reset_n),
    .push  (push),
    .din   (push_data),
    .pop   (out_valid & out_ready),
    .flush (flush),
    .dout  (out_data),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_a2bus_capture_mux.sv
// Scenario bench for a2bus_capture_mux: expected packets queued as stimulus is
// driven, observed transfers collected by a monitor and compared per scenario.
module tb_a2bus_capture_mux;
  import a2bus_stream_pkg::*;

  localparam int NF    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk_logic = 1'b0;
  logic             system_reset_n = 1'b0;
  logic             capture_enable = 1'b1;
  logic             flush = 1'b0;
  logic             clear_stats = 1'b0;
  logic [15:0]      bus_addr = '0;
  logic [7:0]       bus_data = '0;
  logic             bus_rw_n = 1'b1;
  logic             bus_m2sel_n = 1'b1;
  logic             bus_strobe = 1'b0;
  logic [NF-1:0]    flt_en = '0;
  logic [NF*16-1:0] flt_base = '0;
  logic [NF*16-1:0] flt_mask = '0;
  logic [NF*2-1:0]  flt_dir = '0;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready = 1'b1;
  logic [LW-1:0]    fifo_level;
  logic [15:0]      drop_count;
  logic             overflow_flag;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  a2bus_capture_mux #(
    .ENABLE      (1'b1),
    .NUM_FILTERS (NF),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .capture_enable (capture_enable),
    .flush          (flush),
    .clear_stats    (clear_stats),
    .bus_addr       (bus_addr),
    .bus_data       (bus_data),
    .bus_rw_n       (bus_rw_n),
    .bus_m2sel_n    (bus_m2sel_n),
    .bus_strobe     (bus_strobe),
    .flt_en         (flt_en),
    .flt_base       (flt_base),
    .flt_mask       (flt_mask),
    .flt_dir        (flt_dir),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .overflow_flag  (overflow_flag)
  );

  // Clock / reset block
  always #5 clk_logic = ~clk_logic;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Monitor: a transfer is recorded at the negedge before the edge that takes it.
  always @(negedge clk_logic) begin
    if (system_reset_n && out_valid && out_ready) obs_q.push_back(out_data);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic drive_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus_addr    = a;
    bus_data    = d;
    bus_rw_n    = rw;
    bus_strobe  = 1'b1;
    bus_m2sel_n = 1'b0;
    tick();
    bus_strobe  = 1'b0;
    bus_m2sel_n = 1'b1;
  endtask

  function automatic logic [31:0] pkt(input logic [15:0] a, input logic [7:0] d,
                                      input logic rw, input logic [2:0] idx);
    return {a, d, rw, idx, 4'b0000};
  endfunction

  task automatic test_reset();
    logic [31:0] e, o;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow_flag); end
    system_reset_n = 1'b1;
    exp_q.push_back(RESET_MARKER);
    for (int c = 0; c < 50 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (4) @(negedge clk_logic);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_marker_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL reset_marker: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: out_valid got %0b want 0", out_valid); end
    tick();
  endtask

  task automatic test_filter();
    logic [31:0] e, o;
    flt_en   = 4'b0111;
    flt_base = {16'h0000, 16'hC000, 16'h2000, 16'hC03C};
    flt_mask = {16'h0000, 16'hF000, 16'hFFFF, 16'hFFFC};
    flt_dir  = {DIR_ANY, DIR_ANY, DIR_NEVER, DIR_ANY};
    tick();
    drive_cycle(16'hC03D, 8'h5A, 1'b1);
    exp_q.push_back(32'hC03D_5A80);
    tick();
    drive_cycle(16'hC010, 8'h11, 1'b0);
    exp_q.push_back(32'hC010_1120);
    drive_cycle(16'h2000, 8'h33, 1'b1);
    drive_cycle(16'h1234, 8'h44, 1'b0);
    bus_addr = 16'hC100; bus_strobe = 1'b1; bus_m2sel_n = 1'b1;
    tick();
    bus_strobe = 1'b0;
    capture_enable = 1'b0;
    drive_cycle(16'hC101, 8'h55, 1'b1);
    capture_enable = 1'b1;
    for (int c = 0; c < 50 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (5) @(negedge clk_logic);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL filter_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL filter_packet: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] e, o;
    logic [15:0] a;
    logic [7:0]  d;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      a = 16'hC100 + 16'(i);
      d = 8'($urandom_range(0, 255));
      if (i < DEPTH) exp_q.push_back(pkt(a, d, a[0], 3'd2));
      drive_cycle(a, d, a[0]);
    end
    repeat (4) tick();
    checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, DEPTH); end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL ovf_drop_count: got %0d want 3", drop_count); end
    checks++; if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow_flag); end
    drive_cycle(16'hC1F0, 8'hEE, 1'b1);
    repeat (3) tick();
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL pending_drop_count: got %0d want 4", drop_count); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        errors++; $display("FAIL hold_stable: cycle %0d valid %0b data %h want 1 %h", k, out_valid, out_data, exp_q[0]);
      end
    end
    out_ready = 1'b1;
    exp_q.push_back({16'hFFFF, 8'd4, 8'h02});
    for (int c = 0; c < 200 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (3) @(negedge clk_logic);
    tick();
    drive_cycle(16'hC155, 8'h77, 1'b1);
    exp_q.push_back(32'hC155_77A0);
    for (int c = 0; c < 50 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (3) @(negedge clk_logic);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_drain_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ovf_drain_packet: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a  = 16'hC100 | 16'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      rw = 1'($urandom_range(0, 1));
      exp_q.push_back(pkt(a, d, rw, 3'd2));
      drive_cycle(a, d, rw);
    end
    @(negedge clk_logic);
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL b2b_level: got %0d want 1", fifo_level); end
    for (int c = 0; c < 50 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (3) @(negedge clk_logic);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_packet: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL b2b_level_end: got %0d want 0", fifo_level); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_cycle(16'hC200 + 16'(i), 8'(i), 1'b0);
    repeat (3) tick();
    checks++; if (fifo_level !== LW'(5)) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", fifo_level); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL flush_drop_count: got %0d want 4", drop_count); end
    out_ready = 1'b1;
    repeat (5) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL flush_no_output: got %0d packets want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    logic [31:0] e, o;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(16'hC300 + 16'(i), 8'hA0 + 8'(i), 1'b1);
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %0b want 1", out_valid); end
    @(negedge clk_logic);
    #2;
    system_reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL areset_data: got %h want 0", out_data); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL areset_level: got %0d want 0", fifo_level); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL areset_drop_count: got %0d want 0", drop_count); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL areset_flag: got %0b want 0", overflow_flag); end
    tick();
    tick();
    out_ready = 1'b1;
    system_reset_n = 1'b1;
    exp_q.push_back(RESET_MARKER);
    for (int c = 0; c < 50 && obs_q.size() < exp_q.size(); c++) @(negedge clk_logic);
    repeat (3) @(negedge clk_logic);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL areset_marker_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL areset_marker: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tick();
  endtask

  task automatic test_clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(16'hC400 + 16'(i), 8'(i), 1'b0);
    repeat (4) tick();
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL clr_pre_count: got %0d want 1", drop_count); end
    checks++; if (overflow_flag !== 1'b1) begin errors++; $display("FAIL clr_pre_flag: got %0b want 1", overflow_flag); end
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", drop_count); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL clr_flag: got %0b want 0", overflow_flag); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL clr_flush_level: got %0d want 0", fifo_level); end
    out_ready = 1'b1;
    obs_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_clear_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
